// File: rtl/divider_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : divider_arbiter_if
// Brief   : Requester, response and divider-side signals of divider_arbiter.
// Rev     : 1.0
// ============================================================================
interface divider_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 4
);
    localparam int IDW = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]         req;
    logic [N_REQ*WIDTH_A-1:0] a_in;
    logic [N_REQ*WIDTH_B-1:0] b_in;
    logic [N_REQ-1:0]         gnt;
    logic                     rsp_valid;
    logic [IDW-1:0]           rsp_id;
    logic [WIDTH_A-1:0]       rsp_q;
    logic [WIDTH_B-1:0]       rsp_r;
    logic                     rsp_err;
    logic                     div_start;
    logic [WIDTH_A-1:0]       div_a;
    logic [WIDTH_B-1:0]       div_b;
    logic                     div_done;
    logic [WIDTH_A-1:0]       div_q;
    logic [WIDTH_B-1:0]       div_r;

    // Arbiter side
    modport slave (
        input  req, a_in, b_in, div_done, div_q, div_r,
        output gnt, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
               div_start, div_a, div_b
    );

    // Requester/divider environment side
    modport master (
        output req, a_in, b_in, div_done, div_q, div_r,
        input  gnt, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
               div_start, div_a, div_b
    );
endinterface
`default_nettype wire

// File: rtl/divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : divider_arbiter
// Brief   : Round-robin scheduler sharing one divider among N_REQ requesters.
// Rev     : 1.0
// ============================================================================
module divider_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 4,
    parameter int TIMEOUT = 63
) (
    input wire logic         clk,
    input wire logic         reset,
    divider_arbiter_if.slave bus
);
    localparam int IDW = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1;
    localparam int IW  = IDW + 1;
    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] c_NREQ    = IW'(N_REQ);
    localparam logic [CW-1:0] c_TIMEOUT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [IDW-1:0]     r_ptr,       w_ptr_nxt;
    logic [IDW-1:0]     r_id,        w_id_nxt;
    logic               r_armed,     w_armed_nxt;
    logic [CW-1:0]      r_cnt,       w_cnt_nxt;
    logic [N_REQ-1:0]   r_gnt,       w_gnt_nxt;
    logic               r_rsp_valid, w_rsp_valid_nxt;
    logic [IDW-1:0]     r_rsp_id,    w_rsp_id_nxt;
    logic [WIDTH_A-1:0] r_rsp_q,     w_rsp_q_nxt;
    logic [WIDTH_B-1:0] r_rsp_r,     w_rsp_r_nxt;
    logic               r_rsp_err,   w_rsp_err_nxt;
    logic               r_div_start, w_div_start_nxt;
    logic [WIDTH_A-1:0] r_div_a,     w_div_a_nxt;
    logic [WIDTH_B-1:0] r_div_b,     w_div_b_nxt;

    logic               w_found;
    logic [IDW-1:0]     w_sel;
    logic [IW-1:0]      w_idx;
    logic [IW-1:0]      w_sel_inc;
    logic [WIDTH_A-1:0] w_a_sel;
    logic [WIDTH_B-1:0] w_b_sel;
    logic [CW-1:0]      w_cnt_inc;

    // First requester at or above r_ptr, wrapping modulo N_REQ
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = {1'b0, r_ptr} + IW'(i);
            if (w_idx >= c_NREQ) begin
                w_idx = w_idx - c_NREQ;
            end
            if (!w_found && bus.req[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[IDW-1:0];
            end
        end
    end

    assign w_sel_inc = {1'b0, w_sel} + IW'(1);
    assign w_a_sel   = bus.a_in[w_sel*WIDTH_A +: WIDTH_A];
    assign w_b_sel   = bus.b_in[w_sel*WIDTH_B +: WIDTH_B];
    assign w_cnt_inc = r_cnt + CW'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_id_nxt        = r_id;
        w_armed_nxt     = r_armed;
        w_cnt_nxt       = r_cnt;
        w_gnt_nxt       = '0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_id_nxt    = r_rsp_id;
        w_rsp_q_nxt     = r_rsp_q;
        w_rsp_r_nxt     = r_rsp_r;
        w_rsp_err_nxt   = r_rsp_err;
        w_div_start_nxt = 1'b0;
        w_div_a_nxt     = r_div_a;
        w_div_b_nxt     = r_div_b;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt[w_sel] = 1'b1;
                    w_ptr_nxt        = (w_sel_inc == c_NREQ) ? '0 : w_sel_inc[IDW-1:0];
                    w_id_nxt         = w_sel;
                    w_div_a_nxt      = w_a_sel;
                    w_div_b_nxt      = w_b_sel;
                    if (w_b_sel == '0) begin
                        // Divide-by-zero never reaches the divider
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_id_nxt    = w_sel;
                        w_rsp_q_nxt     = '1;
                        w_rsp_r_nxt     = '0;
                        w_rsp_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt     = S_LAUNCH;
                        w_div_start_nxt = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT;
                w_armed_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
            S_WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                if (!bus.div_done) begin
                    w_armed_nxt = 1'b1;
                end
                // A done level left over from the previous operation is only
                // trusted after it has been seen low once in this wait.
                if (r_armed && bus.div_done) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_id_nxt    = r_id;
                    w_rsp_q_nxt     = bus.div_q;
                    w_rsp_r_nxt     = bus.div_r;
                    w_rsp_err_nxt   = 1'b0;
                end else if (w_cnt_inc == c_TIMEOUT) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_id_nxt    = r_id;
                    w_rsp_q_nxt     = '1;
                    w_rsp_r_nxt     = '0;
                    w_rsp_err_nxt   = 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_armed     <= 1'b0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_q     <= '0;
            r_rsp_r     <= '0;
            r_rsp_err   <= 1'b0;
            r_div_start <= 1'b0;
            r_div_a     <= '0;
            r_div_b     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_id        <= w_id_nxt;
            r_armed     <= w_armed_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_id    <= w_rsp_id_nxt;
            r_rsp_q     <= w_rsp_q_nxt;
            r_rsp_r     <= w_rsp_r_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_div_start <= w_div_start_nxt;
            r_div_a     <= w_div_a_nxt;
            r_div_b     <= w_div_b_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_q     = r_rsp_q;
    assign bus.rsp_r     = r_rsp_r;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.div_start = r_div_start;
    assign bus.div_a     = r_div_a;
    assign bus.div_b     = r_div_b;
endmodule
`default_nettype wire

// File: tb/tb_divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_divider_arbiter
// Brief   : Randomized bench for divider_arbiter with a timing-level reference model.
// Rev     : 1.0
// ============================================================================
module tb_divider_arbiter;
    localparam int N   = 4;
    localparam int WA  = 8;
    localparam int WB  = 4;
    localparam int TO  = 63;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    divider_arbiter_if #(.N_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB)) bus ();
    divider_arbiter #(.N_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(rst), .bus(bus));

    int checks = 0, errors = 0, cyc = 0, rst_cnt = 3;
    logic [N-1:0]  req_v = '0;
    logic [WA-1:0] a_v [N];
    logic [WB-1:0] b_v [N];
    bit auto_req = 0, rand_ops = 0;
    int ctl_mode = 0, ctl_D = 4;          // 0 normal, 1 never done, 2 stale done

    // divider model state
    int dk = -1, d_mode = 0, d_D = 2;
    logic [WA-1:0] res_q = '0, prev_q = '0;
    logic [WB-1:0] res_r = '0, prev_r = '0;

    // reference model: last grant, its response time and expected result
    int m_ptr = 0, m_idle_at = 0, g_cyc = -1, g_id = 0, r_cyc = -1;
    logic [WA-1:0] g_a = '0, e_q = '0, h_a = '0, h_q = '0;
    logic [WB-1:0] g_b = '0, e_r = '0, h_b = '0, h_r = '0;
    logic e_err = 1'b0, h_err = 1'b0;
    logic [IDW-1:0] h_id = '0;

    // observations for literal checks
    int gq[$];
    bit rsp_seen = 0, start_in_gnt = 0;
    int last_gnt_cyc = 0, last_rsp_cyc = 0;
    logic [N-1:0] last_gnt = '0;
    logic [IDW-1:0] lr_id = '0;
    logic [WA-1:0] lr_q = '0;
    logic [WB-1:0] lr_r = '0;
    logic lr_err = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare();
        logic [N-1:0] e_gnt;
        if (cyc == g_cyc) begin h_a = g_a; h_b = g_b; end
        if (cyc == r_cyc) begin h_id = IDW'(g_id); h_q = e_q; h_r = e_r; h_err = e_err; end
        e_gnt = '0;
        if (cyc == g_cyc) e_gnt[g_id] = 1'b1;
        chk("gnt", bus.gnt, e_gnt);
        chk("div_start", bus.div_start, (cyc == g_cyc && g_b != '0));
        chk("rsp_valid", bus.rsp_valid, (cyc == r_cyc));
        chk("rsp_id", bus.rsp_id, h_id);
        chk("rsp_q", bus.rsp_q, h_q);
        chk("rsp_r", bus.rsp_r, h_r);
        chk("rsp_err", bus.rsp_err, h_err);
        chk("div_a", bus.div_a, h_a);
        chk("div_b", bus.div_b, h_b);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_idle_at = 0; g_cyc = -1; r_cyc = -1;
        h_a = '0; h_b = '0; h_q = '0; h_r = '0; h_err = 1'b0; h_id = '0;
    endtask

    // Arbitration expressed as timing arithmetic on grant/response cycles
    task automatic advance();
        int id, mode, dd;
        if (rst || cyc < m_idle_at || req_v == '0) return;
        id = -1;
        for (int i = 0; i < N; i++) if (id < 0 && req_v[(m_ptr + i) % N]) id = (m_ptr + i) % N;
        g_id = id; g_cyc = cyc + 1; g_a = a_v[id]; g_b = b_v[id]; m_ptr = (id + 1) % N;
        if (g_b == '0) begin
            r_cyc = cyc + 1; e_q = '1; e_r = '0; e_err = 1'b1;
        end else begin
            if (rand_ops) begin
                dd = $urandom_range(0, 9);
                mode = (dd == 0) ? 1 : (dd <= 2) ? 2 : 0;
                dd = (mode == 2) ? $urandom_range(4, 9) : $urandom_range(2, 9);
            end else begin
                mode = ctl_mode; dd = ctl_D;
            end
            d_mode = mode; d_D = dd;
            if (mode == 1) begin
                r_cyc = cyc + 2 + TO; e_q = '1; e_r = '0; e_err = 1'b1;
            end else begin
                r_cyc = cyc + 2 + dd; e_q = g_a / WA'(g_b); e_r = WB'(g_a % WA'(g_b)); e_err = 1'b0;
            end
        end
        m_idle_at = r_cyc + 1;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        compare();
        if (bus.gnt != '0) begin
            last_gnt = bus.gnt; last_gnt_cyc = cyc; start_in_gnt = bus.div_start;
            for (int i = 0; i < N; i++) if (bus.gnt[i]) gq.push_back(i);
        end
        if (bus.rsp_valid) begin
            rsp_seen = 1; last_rsp_cyc = cyc;
            lr_id = bus.rsp_id; lr_q = bus.rsp_q; lr_r = bus.rsp_r; lr_err = bus.rsp_err;
        end
        // requesters: drop on grant and scramble operands after capture
        for (int i = 0; i < N; i++) begin
            if (bus.gnt[i]) begin
                req_v[i] = 1'b0; a_v[i] = WA'($urandom); b_v[i] = WB'($urandom);
            end
            if (auto_req && !req_v[i] && $urandom_range(0, 3) == 0) begin
                req_v[i] = 1'b1; a_v[i] = WA'($urandom);
                b_v[i] = ($urandom_range(0, 7) == 0) ? '0 : WB'($urandom_range(1, 15));
            end
        end
        // divider model
        if (bus.div_start) begin
            dk = 0; prev_q = res_q; prev_r = res_r;
            res_q = (bus.div_b == '0) ? '1 : bus.div_a / WA'(bus.div_b);
            res_r = (bus.div_b == '0) ? '0 : WB'(bus.div_a % WA'(bus.div_b));
        end else if (dk >= 0) dk++;
        if (dk < 0 || d_mode == 1) begin
            bus.div_done = 1'b0; bus.div_q = WA'($urandom); bus.div_r = WB'($urandom);
        end else if (d_mode == 2 && dk <= 2) begin
            bus.div_done = 1'b1; bus.div_q = prev_q; bus.div_r = prev_r;
        end else if (dk >= d_D) begin
            bus.div_done = 1'b1; bus.div_q = res_q; bus.div_r = res_r;
        end else begin
            bus.div_done = 1'b0; bus.div_q = WA'($urandom); bus.div_r = WB'($urandom);
        end
        bus.req = req_v;
        for (int i = 0; i < N; i++) begin
            bus.a_in[i*WA +: WA] = a_v[i];
            bus.b_in[i*WB +: WB] = b_v[i];
        end
        if (rst_cnt > 0) begin
            rst_cnt--;
            if (rst_cnt == 0) rst = 1'b0;
        end
        advance();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_q", bus.rsp_q, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_div_start", bus.div_start, 0);
        chk("rst_div_a", bus.div_a, 0);
        chk("rst_div_b", bus.div_b, 0);
        model_reset();
        rst_cnt = 3;
    endtask

    task automatic wait_rsp(string nm, int maxc);
        rsp_seen = 0;
        for (int i = 0; i < maxc && !rsp_seen; i++) step();
        chk({nm, "_rsp_seen"}, rsp_seen, 1);
    endtask

    task automatic wait_grants(string nm, int n, int maxc);
        for (int i = 0; i < maxc && gq.size() < n; i++) step();
        chk({nm, "_grants"}, gq.size(), n);
    endtask

    task automatic settle();
        for (int i = 0; i < 200 && cyc <= m_idle_at; i++) step();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin a_v[i] = '0; b_v[i] = '0; end
        bus.req = '0; bus.a_in = '0; bus.b_in = '0;
        bus.div_done = 1'b0; bus.div_q = '0; bus.div_r = '0;
        repeat (4) step();
        chk("reset_rsp_id", bus.rsp_id, 0);

        // contention: all four held
        ctl_mode = 0; ctl_D = 3;
        for (int i = 0; i < N; i++) begin
            req_v[i] = 1'b1; a_v[i] = WA'(8'h31 * (i + 1)); b_v[i] = WB'(i + 2);
        end
        gq.delete();
        wait_grants("contention", 4, 100);
        for (int k = 0; k < 4 && k < gq.size(); k++) chk("order4", gq[k], k);
        settle();
        req_v[0] = 1'b1; a_v[0] = 8'h64; b_v[0] = 4'h3;
        req_v[2] = 1'b1; a_v[2] = 8'h20; b_v[2] = 4'h6;
        gq.delete();
        wait_grants("fresh", 2, 60);
        if (gq.size() == 2) begin chk("order2_0", gq[0], 0); chk("order2_1", gq[1], 2); end
        settle();

        // single request, D=8
        ctl_mode = 0; ctl_D = 8;
        req_v[0] = 1'b1; a_v[0] = 8'h8C; b_v[0] = 4'b1001;
        wait_rsp("single", 40);
        chk("single_gnt", last_gnt, 4'b0001);
        chk("single_start", start_in_gnt, 1);
        chk("single_lat", last_rsp_cyc - last_gnt_cyc, 9);
        chk("single_id", lr_id, 0);
        chk("single_q", lr_q, 8'h0F);
        chk("single_r", lr_r, 4'h5);
        chk("single_err", lr_err, 0);
        settle();

        // divide by zero
        req_v[3] = 1'b1; a_v[3] = 8'h55; b_v[3] = 4'h0;
        wait_rsp("dbz", 20);
        chk("dbz_gnt", last_gnt, 4'b1000);
        chk("dbz_same_cycle", last_rsp_cyc - last_gnt_cyc, 0);
        chk("dbz_start", start_in_gnt, 0);
        chk("dbz_id", lr_id, 3);
        chk("dbz_q", lr_q, 8'hFF);
        chk("dbz_r", lr_r, 0);
        chk("dbz_err", lr_err, 1);
        settle();

        // timeout then a normal operation
        ctl_mode = 1;
        req_v[1] = 1'b1; a_v[1] = 8'h77; b_v[1] = 4'h3;
        wait_rsp("timeout", 100);
        chk("timeout_lat", last_rsp_cyc - last_gnt_cyc, 64);
        chk("timeout_err", lr_err, 1);
        chk("timeout_q", lr_q, 8'hFF);
        settle();
        ctl_mode = 0; ctl_D = 5;
        req_v[2] = 1'b1; a_v[2] = 8'd200; b_v[2] = 4'd7;
        wait_rsp("after_to", 30);
        chk("after_to_q", lr_q, 8'd28);
        chk("after_to_r", lr_r, 4'd4);
        chk("after_to_err", lr_err, 0);
        settle();

        // stale done held for 2 cycles after start
        ctl_mode = 2; ctl_D = 6;
        req_v[0] = 1'b1; a_v[0] = 8'hF3; b_v[0] = 4'hA;
        wait_rsp("stale", 30);
        chk("stale_lat", last_rsp_cyc - last_gnt_cyc, 7);
        chk("stale_q", lr_q, 8'd24);
        chk("stale_r", lr_r, 4'd3);
        settle();

        // reset in WAIT; late done must be ignored
        ctl_mode = 0; ctl_D = 20;
        req_v[2] = 1'b1; a_v[2] = 8'h40; b_v[2] = 4'h5;
        gq.delete();
        wait_grants("pre_reset", 1, 20);
        repeat (5) step();
        apply_reset();
        rsp_seen = 0;
        repeat (30) step();
        chk("no_rsp_after_reset", rsp_seen, 0);
        ctl_D = 4;
        req_v[1] = 1'b1; a_v[1] = 8'h21; b_v[1] = 4'h4;
        wait_rsp("post_reset", 30);
        chk("post_reset_gnt", last_gnt, 4'b0010);
        chk("post_reset_q", lr_q, 8'h08);
        settle();

        // randomized traffic
        rand_ops = 1; auto_req = 1;
        repeat (3000) step();
        auto_req = 0;
        for (int i = 0; i < 300 && (req_v != '0 || cyc <= m_idle_at); i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
